// File: rtl/regfile_wb.sv
// Writeback stage and 32 x XLEN register file. After reset the registers are
// cleared one per cycle (x1..x31), then writes from the WB stage commit on posedge.
module regfile_wb #(
  parameter int XLEN   = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] read_data_w,
  input  logic [XLEN-1:0] alu_result_w,
  input  logic [XLEN-1:0] pc_plus_4w,
  input  logic [1:0]      result_src_w,
  input  logic            reg_write_w,
  input  logic [4:0]      rd_w,
  input  logic [4:0]      rs1_d,
  input  logic [4:0]      rs2_d,
  output logic [XLEN-1:0] rd1_d,
  output logic [XLEN-1:0] rd2_d,
  output logic [XLEN-1:0] result_w,
  output logic            ready,
  output logic [31:0]     wb_count
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state, state_nxt;
  logic [4:0]      clr_idx;
  logic [XLEN-1:0] regs [32];
  logic            commit;

  // NOTE: every variable assigned in always_comb gets a value on every path
  // (here via the default arm), otherwise a latch is inferred.
  always_comb begin
    case (result_src_w)
      2'b00:   result_w = alu_result_w;
      2'b01:   result_w = read_data_w;
      2'b10:   result_w = pc_plus_4w;
      default: result_w = '0;
    endcase
  end

  // Reset has priority, so a write presented alongside rst never lands.
  assign commit = !rst && (state == RUN) && reg_write_w && (rd_w != 5'd0);

  always_comb begin
    state_nxt = state;
    if (state == CLEAR && clr_idx == 5'd31) state_nxt = RUN;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR;
      clr_idx  <= 5'd1;
      ready    <= 1'b0;
      wb_count <= '0;
    end else begin
      state <= state_nxt;
      ready <= (state_nxt == RUN);
      if (state == CLEAR) clr_idx <= clr_idx + 5'd1;
      if (commit)         wb_count <= wb_count + 32'd1;
    end
  end

  // NOTE: the storage array has no reset term; the CLEAR sweep zeroes it and
  // reads are masked to zero until the sweep finishes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) regs[clr_idx] <= '0;
      else if (commit)    regs[rd_w]    <= result_w;
    end
  end

  always_comb begin
    if (state == CLEAR || rs1_d == 5'd0)        rd1_d = '0;
    else if (BYPASS && commit && rd_w == rs1_d) rd1_d = result_w;
    else                                        rd1_d = regs[rs1_d];
  end

  always_comb begin
    if (state == CLEAR || rs2_d == 5'd0)        rd2_d = '0;
    else if (BYPASS && commit && rd_w == rs2_d) rd2_d = result_w;
    else                                        rd2_d = regs[rs2_d];
  end

endmodule

// File: doc/regfile_wb.md
REGFILE_WB -- requirements
Module: regfile_wb

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the data width of registers, results and read ports.
REQ-002 The block SHALL have parameter BYPASS, default 1, enabling write-to-read forwarding when set to 1.
REQ-003 The block SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port read_data_w  input  XLEN  load data from the WB pipeline register.
REQ-006 The block SHALL have port alu_result_w  input  XLEN  ALU result from the WB pipeline register.
REQ-007 The block SHALL have port pc_plus_4w  input  XLEN  link address from the WB pipeline register.
REQ-008 The block SHALL have port result_src_w  input  2  result select: 00 ALU, 01 load, 10 PC+4, 11 reserved.
REQ-009 The block SHALL have port reg_write_w  input  1  write-enable for the WB-stage instruction.
REQ-010 The block SHALL have port rd_w  input  5  destination register index.
REQ-011 The block SHALL have ports rs1_d and rs2_d  input  5  decode-stage source indices.
REQ-012 The block SHALL have ports rd1_d and rd2_d  output  XLEN  source operand values.
REQ-013 The block SHALL have port result_w  output  XLEN  selected writeback value, for forwarding to EX.
REQ-014 The block SHALL have port ready  output  1  high once the register file has finished clearing.
REQ-015 The block SHALL have port wb_count  output  32  count of committed register writes.

Function
REQ-016 The block SHALL drive result_w combinationally: ALU result for 00, load data for 01, PC+4 for 10, zero for 11.
REQ-017 The block SHALL hold 32 registers x0..x31; x0 SHALL never be written and SHALL always read as zero.
REQ-018 The block SHALL have a two-state FSM, CLEAR and RUN, with a 5-bit clear index clr_idx.
REQ-019 In CLEAR, on each posedge with rst low, the block SHALL write zero to x[clr_idx] and increment clr_idx.
REQ-020 When x31 is written in CLEAR, the block SHALL move to RUN on the same edge; ready SHALL equal (state==RUN) and be registered.
REQ-021 In RUN, a write SHALL be committed at posedge when reg_write_w=1 and rd_w!=0: x[rd_w] <= result_w.
REQ-022 In CLEAR, reg_write_w SHALL be ignored, with no register update and no wb_count change.
REQ-023 A write with reg_write_w=1 and rd_w=0 SHALL be discarded and SHALL NOT increment wb_count.
REQ-024 result_src_w=11 with a valid write SHALL commit zero and SHALL count as a committed write.
REQ-025 Reads SHALL be combinational, with zero latency: rdN_d = x[rsN_d]; during CLEAR both rdN_d SHALL read zero.
REQ-026 With BYPASS=1 in RUN, if a write is committing this cycle and rd_w==rsN_d!=0, rdN_d SHALL equal result_w.
REQ-027 With BYPASS=0, rdN_d SHALL return the stored value, and the new value SHALL be visible the cycle after the write.
REQ-028 Both read ports SHALL bypass independently, including when rs1_d==rs2_d==rd_w.
REQ-029 wb_count SHALL increment by 1 per committed write and wrap from 0xFFFFFFFF to 0.

Reset
REQ-030 While rst=1 at a posedge: state=CLEAR, clr_idx=1, ready=0, wb_count=0; registers SHALL NOT be modified by that edge.
REQ-031 rst asserted mid-CLEAR or in RUN SHALL restart the clear from x1; the first edge with rst low clears x1.
REQ-032 ready SHALL rise after the 31st posedge following rst deassertion; no output SHALL be X after the first rst edge.

Verification
REQ-033 Reset sequence: rst 1 for 2 cycles then 0 -> ready=0 for 31 edges, ready=1 after edge 31, and all rd1_d/rd2_d=0.
REQ-034 Write and read: reg_write_w=1, rd_w=5, src=00, alu=0xDEADBEEF -> next cycle rs1_d=5 reads 0xDEADBEEF and wb_count=1.
REQ-035 Bypass: same-cycle rd_w=7 with src=10, pc_plus_4w=0x104, rs1_d=rs2_d=7 -> rd1_d=rd2_d=0x104 in that cycle (BYPASS=1).
REQ-036 x0 and reserved select: write rd_w=0 with data 0x1 -> x0 reads 0 and wb_count unchanged; src=11 to x3 -> x3=0 and count+1.
REQ-037 Write during CLEAR at edge 10 to x9=0x55 -> ignored; after ready, x9 reads 0 and wb_count=0.
REQ-038 rst pulse in RUN, then preload wb_count=0xFFFFFFFF via 2^32 writes or force -> next commit wraps wb_count to 0; rst mid-clear re-clears x1.
